shift_register_ctrl: RTL and testbench

Two-requester arbiter and serializer that sequences the 4-bit serial-in shift register. Each requester offers a parallel word; the controller grants one requester at a time round-robin, captures its word, and drives it MSB-first into the shift register's serial input with a qualifying shift-enable. It sits directly in front of the shift register, with `sdo` feeding the register's serial input.

---
 rtl/shift_register_ctrl.sv | 152 +++++++++++++++
 tb/tb_shift_register_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_ctrl.sv
// Two-requester round-robin arbiter that serializes the granted word MSB-first.
// Optional trailing zero flush enabled by SHIFT_REGISTER_CTRL_FLUSH_EN.
module shift_register_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sdo,
  output logic             sen,
  output logic             busy,
  output logic             owner,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StShift,
`ifdef SHIFT_REGISTER_CTRL_FLUSH_EN
    StFlush,
`endif
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             sdo_q, sdo_d;
  logic             sen_q, sen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             win;

  // On a tie the requester that did not own the last transfer wins.
  assign win = (req0 && req1) ? ~owner_q : req1;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    sdo_d   = 1'b0;
    sen_d   = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d = StGrant;
          owner_d = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          sreg_d  = win ? din1 : din0;
          cnt_d   = CntLast;
        end else begin
          busy_d = 1'b0;
        end
      end
      StGrant: begin
        state_d = StShift;
        sen_d   = 1'b1;
        sdo_d   = sreg_q[WIDTH-1];
        sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
      end
      StShift: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - CntW'(1);
          sen_d  = 1'b1;
          sdo_d  = sreg_q[WIDTH-1];
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
`ifdef SHIFT_REGISTER_CTRL_FLUSH_EN
          state_d = StFlush;
          cnt_d   = CntLast;
          sen_d   = 1'b1;
`else
          state_d = StDone;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef SHIFT_REGISTER_CTRL_FLUSH_EN
      StFlush: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
          sen_d = 1'b1;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sdo_q   <= 1'b0;
      sen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      sdo_q   <= sdo_d;
      sen_q   <= sen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign sdo   = sdo_q;
  assign sen   = sen_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign done  = done_q;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Randomized bench for shift_register_ctrl: arbitration, serial stream and timing
// checked against a transfer-level model (honours SHIFT_REGISTER_CTRL_FLUSH_EN).
module tb_shift_register_ctrl;

  localparam int W = 4;
`ifdef SHIFT_REGISTER_CTRL_FLUSH_EN
  localparam int FlushCyc = W;
`else
  localparam int FlushCyc = 0;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] din0 = '0;
  logic [W-1:0] din1 = '0;
  logic         gnt0, gnt1, sdo, sen, busy, owner, done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int model_owner = 1;

  shift_register_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .clr  (clr),
    .req0 (req0),
    .din0 (din0),
    .req1 (req1),
    .din1 (din1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .sdo  (sdo),
    .sen  (sen),
    .busy (busy),
    .owner(owner),
    .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg;
    @(negedge clk);
  endtask

  task automatic apply_reset;
    to_neg();
    clr = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    to_neg();
    to_neg();
    clr = 1'b1;
    model_owner = 1;
  endtask

  task automatic drain;
    for (int k = 0; k < 40 && busy; k++) step();
  endtask

  // Waits for the next grant and records the serial stream up to done (no checking here).
  task automatic capture(input bit drop, output int who, output int gcyc, output int dcyc,
                         output logic [31:0] bits, output int nbits);
    who = -1; gcyc = -1; dcyc = -1; bits = '0; nbits = 0;
    for (int k = 0; k < 40 && who < 0; k++) begin
      step();
      if (gnt0 && gnt1) who = 2;
      else if (gnt0) who = 0;
      else if (gnt1) who = 1;
    end
    if (who >= 0) begin
      gcyc = cyc;
      if (drop) begin
        to_neg();
        if (who == 0) req0 = 1'b0;
        if (who == 1) req1 = 1'b0;
      end
      step();
      for (int k = 0; k < 80 && dcyc < 0; k++) begin
        if (done) dcyc = cyc;
        else begin
          if (sen) begin
            bits = {bits[30:0], sdo};
            nbits++;
          end
          step();
        end
      end
    end
  endtask

  task automatic test_reset;
    to_neg();
    req0 = 1'b1;
    din0 = W'($urandom);
    clr = 1'b0;
    step();
    step();
    n_cmp++;
    if ({gnt0, gnt1, sdo, sen, busy, done} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 000000", {gnt0, gnt1, sdo, sen, busy, done});
    end
    n_cmp++;
    if (owner !== 1'b1) begin
      n_err++;
      $display("FAIL reset_owner: got %b want 1", owner);
    end
    to_neg();
    clr = 1'b1;
    model_owner = 1;
    step();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_first_grant: got %b want 10", {gnt0, gnt1});
    end
    model_owner = 0;
    to_neg();
    req0 = 1'b0;
    drain();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drain: busy got %b want 0", busy);
    end
  endtask

  task automatic test_single;
    int who, g, d, nb;
    logic [31:0] bits;
    apply_reset();
    req0 = 1'b1;
    din0 = 4'b1011;
    capture(1'b1, who, g, d, bits, nb);
    n_cmp++;
    if (who !== 0) begin
      n_err++;
      $display("FAIL single_who: got %0d want 0", who);
    end
    n_cmp++;
    if (bits !== (32'(din0) << FlushCyc) || nb != W + FlushCyc) begin
      n_err++;
      $display("FAIL single_stream: got %h/%0d want %h/%0d", bits, nb,
               32'(din0) << FlushCyc, W + FlushCyc);
    end
    n_cmp++;
    if (d - g != W + 1 + FlushCyc) begin
      n_err++;
      $display("FAIL single_done_lat: got %0d want %0d", d - g, W + 1 + FlushCyc);
    end
    n_cmp++;
    if (bits[W-1:0] !== ((FlushCyc != 0) ? W'(0) : din0)) begin
      n_err++;
      $display("FAIL single_downstream: got %h", bits[W-1:0]);
    end
    model_owner = 0;
    step();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL single_after_done: busy,done got %b want 00", {busy, done});
    end
  endtask

  task automatic test_tie;
    int who, g, d, nb, exp_who, prev_g;
    logic [31:0] bits;
    logic [W-1:0] word;
    apply_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    din0 = 4'hA;
    din1 = 4'h5;
    prev_g = -1;
    for (int i = 0; i < 4; i++) begin
      exp_who = 1 - model_owner;
      word = (exp_who == 1) ? din1 : din0;
      capture(1'b0, who, g, d, bits, nb);
      n_cmp++;
      if (who != exp_who) begin
        n_err++;
        $display("FAIL tie_who[%0d]: got %0d want %0d", i, who, exp_who);
      end
      n_cmp++;
      if (bits !== (32'(word) << FlushCyc) || nb != W + FlushCyc) begin
        n_err++;
        $display("FAIL tie_stream[%0d]: got %h want %h", i, bits, 32'(word) << FlushCyc);
      end
      if (prev_g >= 0) begin
        n_cmp++;
        if (g - prev_g != W + 3 + FlushCyc) begin
          n_err++;
          $display("FAIL tie_spacing[%0d]: got %0d want %0d", i, g - prev_g, W + 3 + FlushCyc);
        end
      end
      prev_g = g;
      model_owner = exp_who;
    end
    to_neg();
    req0 = 1'b0;
    req1 = 1'b0;
    drain();
  endtask

  task automatic test_late;
    int who, g, d, nb, n_g1, dc;
    bit seen;
    logic [31:0] bits;
    apply_reset();
    req0 = 1'b1;
    din0 = W'($urandom);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = gnt0;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL late_gnt0: got none want pulse");
    end
    to_neg();
    req0 = 1'b0;
    step();
    step();
    to_neg();
    req1 = 1'b1;
    din1 = W'($urandom);
    n_g1 = 0;
    dc = -1;
    for (int k = 0; k < 40 && dc < 0; k++) begin
      step();
      if (gnt1) n_g1++;
      if (done) dc = cyc;
    end
    n_cmp++;
    if (n_g1 != 0 || dc < 0) begin
      n_err++;
      $display("FAIL late_ignored: gnt1 count %0d done cycle %0d want 0 / seen", n_g1, dc);
    end
    capture(1'b1, who, g, d, bits, nb);
    n_cmp++;
    if (who != 1 || g != dc + 2) begin
      n_err++;
      $display("FAIL late_grant: who %0d at +%0d want 1 at +2", who, g - dc);
    end
    n_cmp++;
    if (bits !== (32'(din1) << FlushCyc)) begin
      n_err++;
      $display("FAIL late_stream: got %h want %h", bits, 32'(din1) << FlushCyc);
    end
    model_owner = 1;
  endtask

  task automatic test_mid_reset;
    int who, g, d, nb, n_done;
    bit seen;
    logic [31:0] bits;
    apply_reset();
    req0 = 1'b1;
    din0 = W'($urandom) | 4'b1100;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = gnt0;
    end
    to_neg();
    req0 = 1'b0;
    step();
    step();
    n_cmp++;
    if ({seen, sen, sdo} !== 3'b111) begin
      n_err++;
      $display("FAIL midrst_pre: gnt,sen,sdo got %b want 111", {seen, sen, sdo});
    end
    #2;
    clr = 1'b0;
    #1;
    n_cmp++;
    if ({sen, sdo, busy, done} !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst_async: sen,sdo,busy,done got %b want 0000", {sen, sdo, busy, done});
    end
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done) n_done++;
    end
    to_neg();
    clr = 1'b1;
    model_owner = 1;
    req0 = 1'b1;
    req1 = 1'b1;
    din0 = W'($urandom);
    din1 = W'($urandom);
    capture(1'b1, who, g, d, bits, nb);
    if (done) n_done++;
    n_cmp++;
    if (who != 0 || bits !== (32'(din0) << FlushCyc)) begin
      n_err++;
      $display("FAIL midrst_tie: who %0d stream %h want 0 / %h", who, bits,
               32'(din0) << FlushCyc);
    end
    n_cmp++;
    if (n_done != 1) begin
      n_err++;
      $display("FAIL midrst_no_done: done pulses %0d want 1", n_done);
    end
    capture(1'b1, who, g, d, bits, nb);
    n_cmp++;
    if (who != 1 || bits !== (32'(din1) << FlushCyc)) begin
      n_err++;
      $display("FAIL midrst_next: who %0d stream %h want 1 / %h", who, bits,
               32'(din1) << FlushCyc);
    end
    model_owner = 1;
    drain();
  endtask

  task automatic test_flush;
    int who, g, d, nb;
    logic [31:0] bits;
    apply_reset();
    req0 = 1'b1;
    din0 = 4'hF;
    capture(1'b1, who, g, d, bits, nb);
    n_cmp++;
    if (bits !== (32'hF << FlushCyc) || nb != W + FlushCyc) begin
      n_err++;
      $display("FAIL flush_stream: got %h/%0d want %h/%0d", bits, nb, 32'hF << FlushCyc,
               W + FlushCyc);
    end
    n_cmp++;
    if (bits[W-1:0] !== ((FlushCyc != 0) ? W'(0) : W'(4'hF))) begin
      n_err++;
      $display("FAIL flush_downstream: got %h", bits[W-1:0]);
    end
    model_owner = 0;
  endtask

  task automatic test_random;
    int who, g, d, nb, exp_who;
    logic [31:0] bits;
    logic [W-1:0] word;
    apply_reset();
    for (int it = 0; it < 30; it++) begin
      to_neg();
      if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1'b1;
        din0 = W'($urandom);
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1'b1;
        din1 = W'($urandom);
      end
      if (!req0 && !req1) begin
        req0 = 1'b1;
        din0 = W'($urandom);
      end
      exp_who = (req0 && req1) ? 1 - model_owner : (req1 ? 1 : 0);
      word = (exp_who == 1) ? din1 : din0;
      capture(1'b1, who, g, d, bits, nb);
      n_cmp++;
      if (who != exp_who || bits !== (32'(word) << FlushCyc) || nb != W + FlushCyc
          || d - g != W + 1 + FlushCyc) begin
        n_err++;
        $display("FAIL rand[%0d]: who %0d bits %h n %0d lat %0d want %0d %h %0d %0d", it, who,
                 bits, nb, d - g, exp_who, 32'(word) << FlushCyc, W + FlushCyc,
                 W + 1 + FlushCyc);
      end
      model_owner = exp_who;
    end
    to_neg();
    req0 = 1'b0;
    req1 = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_late();
    test_mid_reset();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
